// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-master round-robin Wishbone arbiter with grant watchdog
// Instruction and data masters share one slave port; a stalled grant is ended by a timeout ack.
module wb_arb2 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_stb_i,
  input  logic [31:0] imem_adr_i,
  output logic [31:0] imem_dat_o,
  output logic        imem_ack_o,
  input  logic        dmem_stb_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_be_i,
  input  logic [31:0] dmem_adr_i,
  input  logic [31:0] dmem_dat_i,
  output logic [31:0] dmem_dat_o,
  output logic        dmem_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic        tmo_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

  state_e     state_q, state_d;
  logic       last_d_q, last_d_d;
  logic [7:0] cnt_q, cnt_d;

  logic gnt_i, gnt_d, cur_stb, expire, ack_ev, tmo_ev;

  always_comb begin
    gnt_i   = (state_q == GNT_I);
    gnt_d   = (state_q == GNT_D);
    cur_stb = (gnt_i & imem_stb_i) | (gnt_d & dmem_stb_i);
    expire  = (TMO_LIMIT != 32'd0) && (32'(cnt_q) == TMO_LIMIT);
    // a real slave ack in the expiry cycle takes precedence over the watchdog
    ack_ev  = cur_stb & s_ack_i;
    tmo_ev  = cur_stb & ~s_ack_i & expire;
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (imem_stb_i && (!dmem_stb_i || last_d_q)) begin
          state_d  = GNT_I;
          last_d_d = 1'b0;
        end else if (dmem_stb_i) begin
          state_d  = GNT_D;
          last_d_d = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (!cur_stb || ack_ev || tmo_ev) begin
          state_d = IDLE;
        end
        if (!s_ack_i && (cnt_q != 8'hFF)) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

  // every output is held low while reset is asserted, even mid-grant
  always_comb begin
    s_cyc_o    = cur_stb & ~rst_i;
    s_stb_o    = cur_stb & ~rst_i;
    s_we_o     = gnt_d & dmem_we_i & ~rst_i;
    s_be_o     = (gnt_d && !rst_i) ? dmem_be_i : 4'd0;
    s_dat_o    = (gnt_d && !rst_i) ? dmem_dat_i : 32'd0;
    s_adr_o    = 32'd0;
    if (!rst_i) begin
      if (gnt_i) begin
        s_adr_o = imem_adr_i;
      end else if (gnt_d) begin
        s_adr_o = dmem_adr_i;
      end
    end
    imem_ack_o = gnt_i & (ack_ev | tmo_ev) & ~rst_i;
    dmem_ack_o = gnt_d & (ack_ev | tmo_ev) & ~rst_i;
    imem_dat_o = (tmo_ev || rst_i) ? 32'd0 : s_dat_i;
    dmem_dat_o = (tmo_ev || rst_i) ? 32'd0 : s_dat_i;
    tmo_o      = tmo_ev & ~rst_i;
  end

endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the max cycles a grant waits for slave ack (0 disables the watchdog).
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports imem_stb_i (in, 1), imem_adr_i (in, 32), imem_dat_o (out, 32) and imem_ack_o (out, 1), forming the read-only instruction master.
REQ-005 The block SHALL have ports dmem_stb_i (in, 1), dmem_we_i (in, 1), dmem_be_i (in, 4), dmem_adr_i (in, 32), dmem_dat_i (in, 32), dmem_dat_o (out, 32) and dmem_ack_o (out, 1), forming the data master.
REQ-006 The block SHALL have ports s_cyc_o, s_stb_o, s_we_o (out, 1 each), s_be_o (out, 4), s_adr_o and s_dat_o (out, 32 each), s_dat_i (in, 32) and s_ack_i (in, 1), forming the shared memory slave port.
REQ-007 The block SHALL have port tmo_o, output, 1, a one-cycle pulse on watchdog expiry.

Function
REQ-008 The block SHALL implement the states IDLE, GNT_I and GNT_D in a registered state machine.
REQ-009 In IDLE with only imem_stb_i high, the next state SHALL be GNT_I; with only dmem_stb_i high, the next state SHALL be GNT_D.
REQ-010 In IDLE with both strobes high, the block SHALL grant the master not granted last (round-robin), using a registered last_d flag.
REQ-011 The last_d flag SHALL update on every grant: 1 for GNT_D, 0 for GNT_I.
REQ-012 In GNT_x, s_cyc_o and s_stb_o SHALL equal that master's stb; s_adr_o SHALL be that master's address.
REQ-013 In GNT_D, s_we_o, s_be_o and s_dat_o SHALL equal dmem_we_i, dmem_be_i and dmem_dat_i.
REQ-014 In GNT_I and in IDLE, s_we_o, s_be_o and s_dat_o SHALL be 0.
REQ-015 In IDLE, s_cyc_o and s_stb_o SHALL be 0; the slave is never strobed without a grant.
REQ-016 The granted master's ack SHALL be combinationally s_ack_i while in its grant state; the other master's ack SHALL be 0.
REQ-017 imem_dat_o and dmem_dat_o SHALL both carry s_dat_i, forced to 0 on a timeout ack.
REQ-018 On s_ack_i in GNT_x, the next state SHALL be IDLE (one turnaround cycle; minimum request-to-ack is 2 cycles with a 1-cycle slave).
REQ-019 If the granted master drops its stb before ack, the block SHALL return to IDLE next cycle and ack no one.
REQ-020 A grant counter SHALL clear on entry to GNT_x and increment each cycle without s_ack_i.
REQ-021 When the counter reaches TIMEOUT (TIMEOUT>0), the block SHALL assert the granted master's ack with data 0, pulse tmo_o for that cycle, and go to IDLE.
REQ-022 An s_ack_i in the same cycle as expiry SHALL win: normal ack with s_dat_i, tmo_o stays 0.
REQ-023 The grant counter SHALL be 8 bits wide and SHALL saturate, never wrap.
REQ-024 The block SHALL ignore s_ack_i arriving in IDLE.

Reset
REQ-025 While rst_i is high, the state SHALL be IDLE, last_d 1 (so imem wins the first tie), the counter 0, and all outputs 0.
REQ-026 A reset asserted mid-transaction SHALL abort the grant with no ack to either master and no tmo_o pulse.

Verification
REQ-027 Bench: imem_stb_i high at cycle 0, 1-cycle slave -> s_stb_o high at cycle 1, imem_ack_o at cycle 2, state IDLE at cycle 3.
REQ-028 Bench: both strobes held high after reset -> grants alternate I, D, I, D; dmem_ack_o never coincides with imem_ack_o.
REQ-029 Bench: dmem write adr 0x100, dat 0xA5A5A5A5, be 0xF -> slave sees s_we_o=1, s_be_o=0xF, s_dat_o=0xA5A5A5A5 only in GNT_D.
REQ-030 Bench: TIMEOUT=4, slave never acks -> master ack and tmo_o pulse 4 cycles after grant, data 0x00000000.
REQ-031 Bench: rst_i during GNT_D with ack pending -> no dmem_ack_o, s_stb_o 0 next cycle, first post-reset tie goes to imem.
REQ-032 Bench: s_ack_i coincident with timeout expiry (TIMEOUT=3, ack on 3rd cycle) -> normal ack with slave data, tmo_o 0.
